// File: rtl/serial_tx_if.sv
// serial_tx_if: pop-side handshake between the 16x9 transmit FIFO and the
// UART transmit stage.
//
// Handshake: rd_request is a one-cycle pop pulse raised by the consumer
// only while empty is low; the FIFO presents the popped word on rd_data
// the cycle after rd_request and holds it until the next pop.
interface serial_tx_if;
   logic       empty;
   logic [8:0] rd_data;
   logic       rd_request;

   // Transmit stage side: consumes words, issues pops.
   modport master (
      input  empty,
      input  rd_data,
      output rd_request
   );

   // FIFO side: supplies words, receives pops.
   modport slave (
      output empty,
      output rd_data,
      input  rd_request
   );
endinterface

// File: rtl/serial_tx.sv
// serial_tx: UART transmit stage. Pops 9-bit words from the transmit FIFO,
// frames them (start, 5-8 data bits, optional parity / 9th bit, 1-2 stop
// bits) and shifts them out LSB-first on tx at a fractional baud rate set
// by brd (integer part above BRD_FRAC_BITS, fraction below).
//
// Build option: define SERIAL_TX_BREAK_EN to make control[6] hold tx low
// (line break) while idle and suppress FIFO pops. Without it control[6]
// is ignored.
//
// state_dbg mirrors the FSM state for observation:
//   0 IDLE, 1 FETCH, 2 LOAD, 3 START, 4 DATA, 5 PARITY, 6 STOP.
module serial_tx #(
   parameter int BRD_FRAC_BITS = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] control,
   input  logic [31:0] brd,
   serial_tx_if.master fifo,
   output logic        tx,
   output logic        busy,
   output logic        tx_done,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      LOAD   = 3'd2,
      START  = 3'd3,
      DATA   = 3'd4,
      PARITY = 3'd5,
      STOP   = 3'd6
   } state_t;

   // One bit period's worth of accumulator increment is 2**BRD_FRAC_BITS
   // per clock; a bit ends when the sum reaches the latched brd.
   localparam logic [32:0] ACC_STEP = 33'(1) << BRD_FRAC_BITS;

   state_t      state;
   logic [7:0]  shift;
   logic [3:0]  bit_cnt;
   logic [3:0]  nbits;
   logic [1:0]  par_mode;
   logic        two_stop;
   logic        stop_second;
   logic        par;
   logic        bit8;
   logic [31:0] brd_l;
   logic [32:0] acc;

   logic [32:0] acc_sum;
   logic        tick;
   logic        brd_ok;
   logic        par_bit;
   logic        brk;

`ifdef SERIAL_TX_BREAK_EN
   assign brk = control[6];
   logic unused_ctrl;
   assign unused_ctrl = ^control[31:7];
`else
   assign brk = 1'b0;
   logic unused_ctrl;
   assign unused_ctrl = ^control[31:6];
`endif

   assign acc_sum   = acc + ACC_STEP;
   assign tick      = (acc_sum >= {1'b0, brd_l});
   // Fewer than two clocks per bit cannot be framed; the line stays idle.
   assign brd_ok    = ((brd >> BRD_FRAC_BITS) >= 32'd2);
   assign state_dbg = state;

   // Parity / 9th-bit value sent after the data bits, from the latched mode.
   always_comb begin
      par_bit = 1'b0;
      case (par_mode)
         2'b01:   par_bit = par;
         2'b10:   par_bit = ~par;
         2'b11:   par_bit = bit8;
         default: par_bit = 1'b0;
      endcase
   end

   // Framing FSM with baud accumulator; all outputs are registered here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         tx              <= 1'b1;
         busy            <= 1'b0;
         tx_done         <= 1'b0;
         fifo.rd_request <= 1'b0;
         acc             <= '0;
         shift           <= '0;
         bit_cnt         <= '0;
         nbits           <= 4'd5;
         par_mode        <= 2'b00;
         two_stop        <= 1'b0;
         stop_second     <= 1'b0;
         par             <= 1'b0;
         bit8            <= 1'b0;
         brd_l           <= '0;
      end else begin
         fifo.rd_request <= 1'b0;
         tx_done         <= 1'b0;

         // Bit-timing accumulator runs only while a bit is on the line;
         // the remainder carries over so fractional rates average out.
         if (state == START || state == DATA || state == PARITY || state == STOP) begin
            acc <= tick ? (acc_sum - {1'b0, brd_l}) : acc_sum;
         end

         case (state)
            IDLE: begin
               tx <= ~brk;
               if (control[0] && !fifo.empty && brd_ok && !brk) begin
                  fifo.rd_request <= 1'b1;
                  state           <= FETCH;
               end
            end

            FETCH: begin
               // The popped word appears on rd_data during LOAD.
               busy  <= 1'b1;
               state <= LOAD;
            end

            LOAD: begin
               shift    <= fifo.rd_data[7:0];
               bit8     <= fifo.rd_data[8];
               nbits    <= {2'b00, control[2:1]} + 4'd5;
               par_mode <= control[4:3];
               two_stop <= control[5];
               brd_l    <= brd;
               acc      <= '0;
               tx       <= 1'b0;
               state    <= START;
            end

            START: begin
               if (tick) begin
                  tx      <= shift[0];
                  par     <= shift[0];
                  shift   <= shift >> 1;
                  bit_cnt <= 4'd1;
                  state   <= DATA;
               end
            end

            DATA: begin
               if (tick) begin
                  if (bit_cnt == nbits) begin
                     if (par_mode != 2'b00) begin
                        tx    <= par_bit;
                        state <= PARITY;
                     end else begin
                        tx          <= 1'b1;
                        stop_second <= 1'b0;
                        state       <= STOP;
                     end
                  end else begin
                     tx      <= shift[0];
                     par     <= par ^ shift[0];
                     shift   <= shift >> 1;
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
            end

            PARITY: begin
               if (tick) begin
                  tx          <= 1'b1;
                  stop_second <= 1'b0;
                  state       <= STOP;
               end
            end

            STOP: begin
               if (tick) begin
                  if (two_stop && !stop_second) begin
                     stop_second <= 1'b1;
                  end else begin
                     busy    <= 1'b0;
                     tx_done <= 1'b1;
                     state   <= IDLE;
                  end
               end
            end

            default: begin
               tx    <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed bench for serial_tx. A FIFO model feeds words;
// each pushed word also queues its expected frame, which a line receiver
// pops and checks cycle by cycle against the nominal bit boundaries.
module tb_serial_tx;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] control;
   logic [31:0] brd;
   logic        tx;
   logic        busy;
   logic        tx_done;
   logic [2:0]  state_dbg;

   serial_tx_if fifo_if();

   serial_tx dut (
      .clk       (clk),
      .reset     (reset),
      .control   (control),
      .brd       (brd),
      .fifo      (fifo_if),
      .tx        (tx),
      .busy      (busy),
      .tx_done   (tx_done),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Expected frames: [15:12] length in bits, [11:0] line bits in order.
   logic [15:0] exp_q[$];
   logic [8:0]  fifo_q[$];

   int  cycle_n   = 0;
   int  rq_count  = 0;
   int  tx_low    = 0;
   int  frames_done = 0;
   int  done_cyc  = 0;
   bit  pop_pend  = 0;
   bit  rx_en     = 1;
   bit  rx_act    = 0;
   bit  post_done = 0;
   bit  gap_chk   = 0;
   int  gap_base  = 0;
   int  rx_n      = 0;
   int  cur_b     = 0;
   logic [15:0] cur;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] make_frame(input logic [8:0] w, input logic [31:0] c);
      logic [11:0] b;
      int n, len;
      logic p;
      b = '0;
      len = 0;
      p = 1'b0;
      n = int'(c[2:1]) + 5;
      b[len] = 1'b0; len++;
      for (int i = 0; i < n; i++) begin
         b[len] = w[i];
         p ^= w[i];
         len++;
      end
      case (c[4:3])
         2'b01: begin b[len] = p;    len++; end
         2'b10: begin b[len] = ~p;   len++; end
         2'b11: begin b[len] = w[8]; len++; end
         default: ;
      endcase
      b[len] = 1'b1; len++;
      if (c[5]) begin b[len] = 1'b1; len++; end
      return {4'(len), b};
   endfunction

   task automatic push_word(input logic [8:0] w);
      fifo_q.push_back(w);
      fifo_if.empty = 1'b0;
      exp_q.push_back(make_frame(w, control));
   endtask

   // Advance one clock and observe just after the edge.
   task automatic cyc();
      int k;
      logic [11:0] bits;
      @(posedge clk);
      #1;
      cycle_n++;
      if (tx === 1'b0) tx_low++;
      if (pop_pend) begin
         pop_pend = 0;
         if (fifo_q.size() > 0) fifo_if.rd_data = fifo_q.pop_front();
         fifo_if.empty = (fifo_q.size() == 0);
      end
      if (fifo_if.rd_request === 1'b1) begin
         rq_count++;
         chk("pop_not_empty", 32'(fifo_q.size() > 0), 1);
         chk("pop_not_busy", 32'(busy), 0);
         pop_pend = 1;
      end
      if (rx_en) begin
         if (!rx_act) begin
            if (post_done) begin
               chk("tx_done_single", 32'(tx_done), 0);
               post_done = 0;
            end
            if (tx === 1'b0) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_frame", 32'(tx), 1);
               end else begin
                  cur    = exp_q.pop_front();
                  cur_b  = int'(brd);
                  rx_act = 1;
                  rx_n   = 0;
                  if (gap_chk && frames_done > gap_base)
                     chk("b2b_gap_lt_bit", 32'((cycle_n - done_cyc) < (cur_b / 256)), 1);
               end
            end
         end
         if (rx_act) begin
            k = (rx_n * 256) / cur_b;
            bits = cur[11:0];
            if (k < int'(cur[15:12])) begin
               chk("rx_bit", 32'(tx), 32'(bits[k]));
               chk("rx_done_low", 32'(tx_done), 0);
               chk("rx_busy", 32'(busy), 1);
            end else begin
               chk("rx_tx_done", 32'(tx_done), 1);
               chk("rx_stop_level", 32'(tx), 1);
               rx_act = 0;
               post_done = 1;
               done_cyc = cycle_n;
               frames_done++;
            end
            rx_n++;
         end
      end
   endtask

   task automatic run_frames(input int n, input int budget);
      int target;
      int cnt;
      target = frames_done + n;
      cnt = 0;
      while (frames_done < target && cnt < budget) begin
         cyc();
         cnt++;
      end
      chk("frames_done", frames_done, target);
      repeat (2) cyc();
   endtask

   task automatic wait_rx(input int min_n, input int budget);
      int cnt;
      cnt = 0;
      while (!(rx_act && rx_n >= min_n) && cnt < budget) begin
         cyc();
         cnt++;
      end
      chk("wait_rx_timeout", 32'(rx_act && rx_n >= min_n), 1);
   endtask

   initial begin
      int rq0, low0;
      reset = 1'b1;
      control = 32'h0;
      brd = 32'h0000_0A00;
      fifo_if.empty = 1'b1;
      fifo_if.rd_data = 9'h000;
      repeat (3) cyc();
      chk("reset_tx", 32'(tx), 1);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_rd_request", 32'(fifo_if.rd_request), 0);
      chk("reset_tx_done", 32'(tx_done), 0);
      chk("reset_state", 32'(state_dbg), 0);
      reset = 1'b0;
      cyc();

      // 8N1, 10 clocks per bit, alternating pattern.
      control = 32'h07;
      rq0 = rq_count;
      push_word(9'h055);
      run_frames(1, 400);
      chk("single_pop", rq_count - rq0, 1);

      // Fractional 10.5 clocks per bit, two frames back-to-back.
      brd = 32'h0000_0A80;
      gap_base = frames_done + 1;
      gap_chk = 1;
      push_word(9'h0FF);
      push_word(9'h000);
      run_frames(2, 800);
      gap_chk = 0;
      brd = 32'h0000_0A00;

      // 7 bits even, 7 bits odd, 5 bits odd.
      control = 32'h0D; push_word(9'h003); run_frames(1, 400);
      control = 32'h15; push_word(9'h003); run_frames(1, 400);
      control = 32'h11; push_word(9'h1F3); run_frames(1, 400);

      // 8 bits, 9th bit from word, two stop bits.
      control = 32'h3F; push_word(9'h1A5); run_frames(1, 500);

      // Reset in the middle of the data bits drops the word.
      control = 32'h07;
      push_word(9'h0A5);
      wait_rx(35, 300);
      rx_en = 0;
      rx_act = 0;
      exp_q.delete();
      reset = 1'b1;
      cyc();
      chk("midreset_tx", 32'(tx), 1);
      chk("midreset_busy", 32'(busy), 0);
      chk("midreset_tx_done", 32'(tx_done), 0);
      reset = 1'b0;
      post_done = 0;
      rx_en = 1;
      cyc();
      push_word(9'h13C);
      run_frames(1, 400);

      // Empty FIFO: no pops, line idle.
      rq0 = rq_count; low0 = tx_low;
      repeat (1000) cyc();
      chk("empty_no_pop", rq_count - rq0, 0);
      chk("empty_tx_high", tx_low - low0, 0);

      // Fewer than two clocks per bit: no pops until brd is legal.
      brd = 32'h0000_0100;
      rq0 = rq_count; low0 = tx_low;
      push_word(9'h0AA);
      repeat (1000) cyc();
      chk("slow_brd_no_pop", rq_count - rq0, 0);
      chk("slow_brd_tx_high", tx_low - low0, 0);
      brd = 32'h0000_0A00;
      run_frames(1, 400);

      // Enable dropped mid-frame: frame completes, next word waits.
      push_word(9'h0C3);
      push_word(9'h05A);
      wait_rx(5, 200);
      control = 32'h06;
      run_frames(1, 400);
      rq0 = rq_count;
      repeat (300) cyc();
      chk("disabled_no_pop", rq_count - rq0, 0);
      control = 32'h07;
      run_frames(1, 400);

`ifdef SERIAL_TX_BREAK_EN
      rx_en = 0;
      control = 32'h47;
      rq0 = rq_count;
      push_word(9'h066);
      repeat (20) cyc();
      chk("break_tx_low", 32'(tx), 0);
      chk("break_no_pop", rq_count - rq0, 0);
      control = 32'h07;
      cyc();
      chk("break_release_tx", 32'(tx), 1);
      rx_en = 1;
      run_frames(1, 400);
`else
      control = 32'h47;
      low0 = tx_low;
      repeat (50) cyc();
      chk("break_ignored", tx_low - low0, 0);
      control = 32'h07;
`endif

      chk("exp_q_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
